md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  E-stage multiply/divide unit with HI/LO registers. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from E.
//  Produces Start and Busy for the D-stage stall controller, which stalls any D-stage MD op while Start|Busy.
//  Models fixed multi-cycle latency. Suppresses all architectural side effects when an exception/interrupt request flushes E.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after a MULT/MULTU start (>=1)
//  DIV_CYCLES   10  busy cycles after a DIV/DIVU start (>=1)
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  reset        in   1   synchronous, active-high
//  E_MDControl  in   4   E-stage op: 0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI,8 MTLO; others = NONE
//  E_A          in   32  rs operand (forwarded)
//  E_B          in   32  rt operand (forwarded)
//  Req          in   1   exception/interrupt flush of E this cycle; blocks start and MTHI/MTLO
//  Start        out  1   combinational: E op is MULT/MULTU/DIV/DIVU and !Req and !Busy
//  Busy         out  1   registered: operation in flight
//  MD_Out       out  32  combinational: HI if op==MFHI, LO if op==MFLO, else 0
// BEHAVIOUR
//  Reset: HI=0, LO=0, count=0, Busy=0, pending result regs=0. Start/MD_Out follow from these.
//  Reset mid-operation aborts the op; HI/LO stay 0, and no late writeback occurs.
//  Start edge:
//    - latch the full 64-bit result into pend_hi/pend_lo.
//    - load count = MULT_CYCLES or DIV_CYCLES.
//    - Busy=1 from the next cycle, for exactly that many cycles.
//  count decrements each cycle while nonzero. On the edge where count goes 1->0, HI<=pend_hi and LO<=pend_lo.
//  Busy = (count!=0). Busy falls and the HI/LO update become visible in the same cycle.
//  Arithmetic:
//    - MULT: {HI,LO} = $signed(A)*$signed(B), 64-bit.
//    - MULTU: unsigned product.
//    - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
//    - DIVU: unsigned quotient/remainder.
//    - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//    - Divide by zero (DIV/DIVU, B==0): op still starts and runs DIV_CYCLES busy cycles; HI/LO keep their old values at completion.
//  MTHI/MTLO: when !Req and !Busy, HI (resp. LO) <= E_A at the edge. Otherwise ignored.
//  Start-class op while Busy: ignored (no restart, no state change). The stall controller prevents this case; it is defined for robustness.
//  Req=1 with a start-class op: Start=0; nothing is latched.
//  Req does not cancel an op already in flight. It completes and writes HI/LO.
//  MFHI/MFLO while Busy: return the current (old) HI/LO; the stall controller prevents this case.
//  No internal bypass: an MTHI in cycle t is visible on MD_Out from cycle t+1.
// STRUCTURE
//  Shared package/header: MD op encodings (MD_NONE..MD_MTLO), default latencies.
//  One sub-module, md_busy_counter:
//    - load/value inputs.
//    - outputs busy and done_pulse (done_pulse = count==1).
//    - width = $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
//  Top level holds HI/LO, the pending regs, the result datapath, and the output muxing.
// TESTING
//  1. MULT A=0xFFFFFFFE (-2), B=3:
//     - Start=1 for 1 cycle, then Busy=1 for exactly 5 cycles.
//     - Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//  2. DIVU A=7, B=2 -> Busy 10 cycles, then LO=3, HI=1. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  3. MTHI 0x12345678, then MTLO 0x9, then MFHI and MFLO -> MD_Out=0x12345678, then 0x9. DIV A=5, B=0 -> HI/LO unchanged after 10 Busy cycles.
//  4. MULT issued with Req=1 -> Start=0, Busy stays 0, HI/LO unchanged. MTLO issued with Req=1 -> LO unchanged.
//  5. MULTU started, then reset asserted at busy cycle 2 -> next cycle Busy=0, HI=LO=0, and no writeback afterwards.
//  6. DIV followed by a MULT presented while Busy -> MULT ignored (Start=0). MTHI while Busy -> ignored. HI/LO end with the DIV result.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings and default latencies.
package md_unit_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_e;

   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_unit_busy_counter.sv
// Down-counter modelling the fixed multiply/divide latency; busy while nonzero,
// done_pulse on the last busy cycle so the owner can commit on the 1->0 edge.
module md_busy_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_value,
   output logic             o_busy,
   output logic             o_done_pulse
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (r_count != '0) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_busy       = (r_count != '0);
   assign o_done_pulse = (r_count == WIDTH'(1));

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: HI/LO registers, result computed at start and
// held in pending registers until the latency counter expires.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDControl,
   input  logic [31:0] E_A,
   input  logic [31:0] E_B,
   input  logic        Req,
   output logic        Start,
   output logic        Busy,
   output logic [31:0] MD_Out
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
   logic        r_pend_wr;

   logic        w_is_mult, w_is_start, w_busy, w_done, w_mt_ok;
   logic [CW-1:0] w_load_val;
   logic signed [63:0] w_smul;
   logic [63:0] w_umul;
   logic [31:0] w_divisor, w_uq, w_ur;
   logic signed [31:0] w_sq, w_sr;
   logic [31:0] w_res_hi, w_res_lo;
   logic        w_res_wr;

   assign w_is_mult  = (E_MDControl == MD_MULT) || (E_MDControl == MD_MULTU);
   assign w_is_start = w_is_mult || (E_MDControl == MD_DIV) || (E_MDControl == MD_DIVU);
   assign Start      = w_is_start && !Req && !w_busy;
   assign w_mt_ok    = !Req && !w_busy;
   assign w_load_val = w_is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);

   md_busy_counter #(.WIDTH(CW)) u_busy_counter (
      .clk          (clk),
      .reset        (reset),
      .i_load       (Start),
      .i_value      (w_load_val),
      .o_busy       (w_busy),
      .o_done_pulse (w_done)
   );

   assign Busy = w_busy;

   // Divisor forced nonzero so the divider never yields X; a zero divisor suppresses writeback.
   assign w_divisor = (E_B == '0) ? 32'd1 : E_B;
   assign w_smul    = $signed(E_A) * $signed(E_B);
   assign w_umul    = {32'd0, E_A} * {32'd0, E_B};
   assign w_sq      = $signed(E_A) / $signed(w_divisor);
   assign w_sr      = $signed(E_A) % $signed(w_divisor);
   assign w_uq      = E_A / w_divisor;
   assign w_ur      = E_A % w_divisor;

   always_comb begin
      w_res_hi = '0;
      w_res_lo = '0;
      w_res_wr = 1'b1;
      case (E_MDControl)
         MD_MULT:  {w_res_hi, w_res_lo} = w_smul;
         MD_MULTU: {w_res_hi, w_res_lo} = w_umul;
         MD_DIV: begin
            if (E_B == '0) begin
               w_res_wr = 1'b0;
            end else if (E_A == 32'h8000_0000 && E_B == '1) begin
               w_res_lo = 32'h8000_0000;
            end else begin
               w_res_hi = w_sr;
               w_res_lo = w_sq;
            end
         end
         MD_DIVU: begin
            w_res_wr = (E_B != '0);
            w_res_hi = w_ur;
            w_res_lo = w_uq;
         end
         default: w_res_wr = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi      <= '0;
         r_lo      <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_pend_wr <= 1'b0;
      end else begin
         if (Start) begin
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_wr <= w_res_wr;
         end
         if (w_done && r_pend_wr) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end
         if (w_mt_ok && E_MDControl == MD_MTHI) r_hi <= E_A;
         if (w_mt_ok && E_MDControl == MD_MTLO) r_lo <= E_A;
      end
   end

   always_comb begin
      MD_Out = '0;
      if (E_MDControl == MD_MFHI) MD_Out = r_hi;
      else if (E_MDControl == MD_MFLO) MD_Out = r_lo;
   end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus a randomized run against
// an arithmetic reference model of HI/LO.
module tb_md_unit;

   logic        clk;
   logic        reset;
   logic [3:0]  E_MDControl;
   logic [31:0] E_A, E_B;
   logic        Req;
   logic        Start, Busy;
   logic [31:0] MD_Out;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi, m_lo;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk         (clk),
      .reset       (reset),
      .E_MDControl (E_MDControl),
      .E_A         (E_A),
      .E_B         (E_B),
      .Req         (Req),
      .Start       (Start),
      .Busy        (Busy),
      .MD_Out      (MD_Out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Architectural result of a start-class op; returns old {HI,LO} when nothing is written.
   function automatic logic [63:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b,
                                              input logic [63:0] old);
      longint sa, sb, q, r, aa, ab;
      longint unsigned ua, ub, p;
      logic [63:0] res;
      res = old;
      case (op)
         1: begin sa = $signed(a); sb = $signed(b); q = sa * sb; res = q; end
         2: begin ua = a; ub = b; p = ua * ub; res = p; end
         3: if (b != 0) begin
               sa = $signed(a); sb = $signed(b);
               aa = (sa < 0) ? -sa : sa;
               ab = (sb < 0) ? -sb : sb;
               q = aa / ab; r = aa % ab;
               if ((sa < 0) != (sb < 0)) q = -q;
               if (sa < 0) r = -r;
               res = {r[31:0], q[31:0]};
            end
         4: if (b != 0) begin ua = a; ub = b; res = {32'(ua % ub), 32'(ua / ub)}; end
         default: res = old;
      endcase
      return res;
   endfunction

   function automatic int ref_latency(input int op);
      if (op == 1 || op == 2) return 5;
      if (op == 3 || op == 4) return 10;
      return 0;
   endfunction

   // Present one op for one cycle, then idle until Busy drops (bounded).
   task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, input logic req,
                         output logic start_seen, output logic [31:0] out_seen, output int busy_cnt);
      E_MDControl = 4'(op); E_A = a; E_B = b; Req = req;
      #1;
      start_seen = Start;
      out_seen   = MD_Out;
      tick();
      E_MDControl = 4'd0; Req = 1'b0;
      busy_cnt = 0;
      while (Busy && busy_cnt < 40) begin
         busy_cnt++;
         tick();
      end
   endtask

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      E_MDControl = 4'd5; #1; hi = MD_Out;
      E_MDControl = 4'd6; #1; lo = MD_Out;
      E_MDControl = 4'd0; #1;
   endtask

   task automatic test_reset();
      logic [31:0] hi, lo;
      reset = 1'b1; E_MDControl = 4'd0; E_A = '0; E_B = '0; Req = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      #1;
      m_hi = '0; m_lo = '0;
      checks++;
      if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
      checks++;
      if (Start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", Start); end
      read_hilo(hi, lo);
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL reset_hilo: got %h/%h expected 0/0", hi, lo);
      end
   endtask

   task automatic test_mult();
      logic st; logic [31:0] o, hi, lo; int bc;
      run_op(1, 32'hFFFF_FFFE, 32'd3, 1'b0, st, o, bc);
      checks++;
      if (st !== 1'b1) begin errors++; $display("FAIL mult_start: got %b expected 1", st); end
      checks++;
      if (Start !== 1'b0) begin errors++; $display("FAIL mult_start_after: got %b expected 0", Start); end
      checks++;
      if (bc != 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 5", bc); end
      read_hilo(hi, lo);
      m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFA;
      checks++;
      if (hi !== m_hi || lo !== m_lo) begin
         errors++; $display("FAIL mult_result: got %h/%h expected %h/%h", hi, lo, m_hi, m_lo);
      end
   endtask

   task automatic test_div();
      logic st; logic [31:0] o, hi, lo; int bc;
      logic [31:0] ta [3] = '{32'd7, 32'hFFFF_FFF9, 32'h8000_0000};
      logic [31:0] tb [3] = '{32'd2, 32'd2, 32'hFFFF_FFFF};
      int          top[3] = '{4, 3, 3};
      logic [63:0] exp[3] = '{{32'd1, 32'd3}, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd0, 32'h8000_0000}};
      for (int i = 0; i < 3; i++) begin
         run_op(top[i], ta[i], tb[i], 1'b0, st, o, bc);
         checks++;
         if (bc != 10) begin errors++; $display("FAIL div_busy_cycles[%0d]: got %0d expected 10", i, bc); end
         read_hilo(hi, lo);
         {m_hi, m_lo} = exp[i];
         checks++;
         if (hi !== m_hi || lo !== m_lo) begin
            errors++; $display("FAIL div_result[%0d]: got %h/%h expected %h/%h", i, hi, lo, m_hi, m_lo);
         end
      end
   endtask

   task automatic test_mt_mf();
      logic st; logic [31:0] o, hi, lo; int bc;
      run_op(7, 32'h1234_5678, 32'd0, 1'b0, st, o, bc);
      run_op(8, 32'h0000_0009, 32'd0, 1'b0, st, o, bc);
      m_hi = 32'h1234_5678; m_lo = 32'h9;
      run_op(5, 32'd0, 32'd0, 1'b0, st, o, bc);
      checks++;
      if (o !== m_hi) begin errors++; $display("FAIL mfhi: got %h expected %h", o, m_hi); end
      run_op(6, 32'd0, 32'd0, 1'b0, st, o, bc);
      checks++;
      if (o !== m_lo) begin errors++; $display("FAIL mflo: got %h expected %h", o, m_lo); end
      run_op(3, 32'd5, 32'd0, 1'b0, st, o, bc);
      checks++;
      if (st !== 1'b1 || bc != 10) begin
         errors++; $display("FAIL div0_busy: start %b cycles %0d expected 1/10", st, bc);
      end
      run_op(4, 32'd5, 32'd0, 1'b0, st, o, bc);
      read_hilo(hi, lo);
      checks++;
      if (hi !== m_hi || lo !== m_lo) begin
         errors++; $display("FAIL div0_hilo: got %h/%h expected %h/%h", hi, lo, m_hi, m_lo);
      end
   endtask

   task automatic test_req();
      logic st; logic [31:0] o, hi, lo; int bc;
      run_op(1, 32'd10, 32'd20, 1'b1, st, o, bc);
      checks++;
      if (st !== 1'b0 || bc != 0) begin
         errors++; $display("FAIL req_mult: start %b busy cycles %0d expected 0/0", st, bc);
      end
      run_op(8, 32'hAAAA_5555, 32'd0, 1'b1, st, o, bc);
      read_hilo(hi, lo);
      checks++;
      if (hi !== m_hi || lo !== m_lo) begin
         errors++; $display("FAIL req_hilo: got %h/%h expected %h/%h", hi, lo, m_hi, m_lo);
      end
      // Req arriving while an op is in flight must not cancel it.
      E_MDControl = 4'd2; E_A = 32'hFFFF_FFFF; E_B = 32'd2; Req = 1'b0;
      tick();
      E_MDControl = 4'd0; Req = 1'b1;
      bc = 0;
      while (Busy && bc < 40) begin bc++; tick(); end
      Req = 1'b0;
      read_hilo(hi, lo);
      m_hi = 32'd1; m_lo = 32'hFFFF_FFFE;
      checks++;
      if (hi !== m_hi || lo !== m_lo || bc != 5) begin
         errors++; $display("FAIL req_inflight: got %h/%h cycles %0d expected %h/%h 5", hi, lo, bc, m_hi, m_lo);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] hi, lo; int late_busy;
      E_MDControl = 4'd2; E_A = 32'h0001_0000; E_B = 32'h0001_0000; Req = 1'b0;
      tick();
      E_MDControl = 4'd0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      checks++;
      if (Busy !== 1'b0) begin errors++; $display("FAIL resetmid_busy: got %b expected 0", Busy); end
      late_busy = 0;
      repeat (8) begin tick(); if (Busy) late_busy++; end
      read_hilo(hi, lo);
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0 || late_busy != 0) begin
         errors++; $display("FAIL resetmid_hilo: got %h/%h busy %0d expected 0/0 0", hi, lo, late_busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] hi, lo; logic [63:0] exp; int bc;
      logic [31:0] old_hi;
      old_hi = m_hi;
      exp = ref_result(3, 32'd100, 32'd7, {m_hi, m_lo});
      bc = 0;
      for (int i = 0; i < 13; i++) begin
         case (i)
            0: begin E_MDControl = 4'd3; E_A = 32'd100; E_B = 32'd7; end
            1: begin
                  E_MDControl = 4'd1; E_A = 32'd9; E_B = 32'd9; #1;
                  checks++;
                  if (Start !== 1'b0) begin errors++; $display("FAIL busy_mult_start: got %b expected 0", Start); end
               end
            2: begin E_MDControl = 4'd7; E_A = 32'hDEAD_BEEF; end
            3: begin
                  E_MDControl = 4'd5; #1;
                  checks++;
                  if (MD_Out !== old_hi) begin errors++; $display("FAIL busy_mfhi: got %h expected %h", MD_Out, old_hi); end
               end
            default: E_MDControl = 4'd0;
         endcase
         tick();
         if (Busy) bc++;
      end
      read_hilo(hi, lo);
      {m_hi, m_lo} = exp;
      checks++;
      if (hi !== m_hi || lo !== m_lo || bc != 10) begin
         errors++; $display("FAIL busy_ignore: got %h/%h cycles %0d expected %h/%h 10", hi, lo, bc, m_hi, m_lo);
      end
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      logic st; logic [31:0] o, a, b, exp_out; logic rq; int op, bc, exp_bc; logic exp_st;
      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 15);
         a  = rand_operand();
         b  = rand_operand();
         rq = ($urandom_range(0, 3) == 0);
         exp_st  = (op >= 1 && op <= 4) && !rq;
         exp_bc  = exp_st ? ref_latency(op) : 0;
         exp_out = (op == 5) ? m_hi : (op == 6) ? m_lo : 32'd0;
         run_op(op, a, b, rq, st, o, bc);
         checks++;
         if (st !== exp_st || o !== exp_out || bc != exp_bc) begin
            errors++;
            $display("FAIL rand_op[%0d] op=%0d: start %b out %h cycles %0d expected %b %h %0d",
                     n, op, st, o, bc, exp_st, exp_out, exp_bc);
         end
         if (exp_st) {m_hi, m_lo} = ref_result(op, a, b, {m_hi, m_lo});
         if (op == 7 && !rq) m_hi = a;
         if (op == 8 && !rq) m_lo = a;
         read_hilo(a, b);
         checks++;
         if (a !== m_hi || b !== m_lo) begin
            errors++; $display("FAIL rand_hilo[%0d]: got %h/%h expected %h/%h", n, a, b, m_hi, m_lo);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mt_mf();
      test_req();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
